// File: rtl/top_sram.sv
// Button-driven asynchronous SRAM controller: synchronized buttons, write/read FSM, LED readback.
// Optional BTN_DEBOUNCE_EN adds a stable-low debounce filter (DEBOUNCE_CYCLES) on each button.
module top_sram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
`ifdef BTN_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_req,
    input  logic              read_req,
    output logic [DATA_W-1:0] led_out,
    output logic              we_n,
    output logic              oe_n,
    output logic              ce_n,
    output logic [ADDR_W-1:0] addr_out,
    inout  wire  [DATA_W-1:0] sram_dq
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_SETUP,
        R_WAIT,
        R_LATCH
    } state_t;

    // Bit 0 carries the write button, bit 1 the read button.
    logic [1:0] btn_p0;
    logic [1:0] btn_p1;
    logic [1:0] req;

    // Stage p0/p1: two-flop synchronizer, released (high) on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= 2'b11;
            btn_p1 <= 2'b11;
        end else begin
            btn_p0 <= {read_req, write_req};
            btn_p1 <= btn_p0;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       db_armed;

    // Count consecutive low cycles; a button must go high again to re-arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_armed <= 2'b11;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_p1[i]) begin
                    db_cnt[i]   <= '0;
                    db_armed[i] <= 1'b1;
                end else if (db_armed[i]) begin
                    if (db_cnt[i] == CNT_LAST) db_armed[i] <= 1'b0;
                    else                       db_cnt[i]   <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        req = 2'b00;
        for (int i = 0; i < 2; i++)
            req[i] = db_armed[i] & ~btn_p1[i] & (db_cnt[i] == CNT_LAST);
    end
`else
    logic [1:0] btn_p2;

    // Stage p2: previous synchronized level for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) btn_p2 <= 2'b11;
        else     btn_p2 <= btn_p1;
    end

    assign req = btn_p2 & ~btn_p1;
`endif

    state_t            state, state_nxt;
    logic              pulse_cnt, pulse_cnt_nxt;
    logic              we_n_nxt, oe_n_nxt, ce_n_nxt;
    logic              dq_oe, dq_oe_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] dq_out, dq_out_nxt;

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_nxt     = state;
        pulse_cnt_nxt = 1'b0;
        addr_nxt      = addr_out;
        dq_out_nxt    = dq_out;
        case (state)
            IDLE: begin
                if (req[0]) begin
                    state_nxt  = W_SETUP;
                    addr_nxt   = addr_in;
                    dq_out_nxt = data_in;
                end else if (req[1]) begin
                    state_nxt = R_SETUP;
                    addr_nxt  = addr_in;
                end
            end
            W_SETUP: state_nxt = W_PULSE;
            W_PULSE: begin
                pulse_cnt_nxt = 1'b1;
                if (pulse_cnt) begin
                    state_nxt     = W_HOLD;
                    pulse_cnt_nxt = 1'b0;
                end
            end
            W_HOLD:  state_nxt = IDLE;
            R_SETUP: state_nxt = R_WAIT;
            R_WAIT:  state_nxt = R_LATCH;
            R_LATCH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        ce_n_nxt  = (state_nxt == IDLE);
        we_n_nxt  = (state_nxt != W_PULSE);
        oe_n_nxt  = !(state_nxt inside {R_SETUP, R_WAIT, R_LATCH});
        dq_oe_nxt = (state_nxt inside {W_SETUP, W_PULSE, W_HOLD});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pulse_cnt <= 1'b0;
            we_n      <= 1'b1;
            oe_n      <= 1'b1;
            ce_n      <= 1'b1;
            dq_oe     <= 1'b0;
            addr_out  <= '0;
            led_out   <= '0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= pulse_cnt_nxt;
            we_n      <= we_n_nxt;
            oe_n      <= oe_n_nxt;
            ce_n      <= ce_n_nxt;
            dq_oe     <= dq_oe_nxt;
            addr_out  <= addr_nxt;
            if (state == R_LATCH) led_out <= sram_dq;
        end
    end

    // Write data register is gated by dq_oe, so it needs no reset.
    always_ff @(posedge clk) begin
        dq_out <= dq_out_nxt;
    end

    assign sram_dq = dq_oe ? dq_out : {DATA_W{1'bz}};

endmodule

// File: tb/tb_top_sram.sv
// Directed bench for top_sram: behavioural SRAM on the bus, bus monitor, immediate assertions.
module tb_top_sram;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic              write_req;
    logic              read_req;
    logic [DATA_W-1:0] led_out;
    logic              we_n, oe_n, ce_n;
    logic [ADDR_W-1:0] addr_out;
    wire  [DATA_W-1:0] dq;

    logic [DATA_W-1:0] mem [256];

    int   vectors = 0;
    int   miscompares = 0;
    int   we_pulses = 0;
    int   we_low = 0;
    int   oe_cycles = 0;
    int   p0, l0, o0;
    logic prev_we_n = 1'b1;

    always #5 clk = ~clk;

    // SRAM drives the bus only for a read access.
    assign dq = (!ce_n && !oe_n && we_n) ? mem[addr_out] : {DATA_W{1'bz}};

    top_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .write_req(write_req),
        .read_req (read_req),
        .led_out  (led_out),
        .we_n     (we_n),
        .oe_n     (oe_n),
        .ce_n     (ce_n),
        .addr_out (addr_out),
        .sram_dq  (dq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        p0 = we_pulses;
        l0 = we_low;
        o0 = oe_cycles;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        addr_in   = a;
        data_in   = d;
        write_req = 1'b0;
        tick(1);
        write_req = 1'b1;
        tick(8);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        addr_in  = a;
        read_req = 1'b0;
        tick(1);
        read_req = 1'b1;
        tick(7);
    endtask

    // Bus monitor: SRAM write capture, pulse counting, contention checks.
    always @(negedge clk) begin
        if (!we_n && prev_we_n) we_pulses++;
        if (!we_n) begin
            we_low++;
            if (!ce_n) mem[addr_out] = dq;
            chk("oe_during_write", {31'd0, oe_n}, 32'd1);
        end
        if (!oe_n) begin
            oe_cycles++;
            chk("read_bus_clean", {22'd0, dq}, {22'd0, mem[addr_out]});
        end
        prev_we_n = we_n;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; write_req = 1'b1; read_req = 1'b1;
        addr_in = '0; data_in = '0;
        tick(3);
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
        chk("rst_ce_n", {31'd0, ce_n}, 32'd1);
        chk("rst_addr", {24'd0, addr_out}, 32'h0);
        chk("rst_led", {22'd0, led_out}, 32'h0);
        rst = 1'b0;
        tick(2);

        snap();
        do_write(8'hA5, 10'h15A);
        chk("w_a5_pulses", we_pulses - p0, 32'd1);
        chk("w_a5_low", we_low - l0, 32'd2);
        chk("w_a5_no_oe", oe_cycles - o0, 32'd0);
        chk("w_a5_idle", {31'd0, ce_n}, 32'd1);
        chk("w_a5_addr", {24'd0, addr_out}, 32'hA5);
        chk("w_a5_mem", {22'd0, mem[8'hA5]}, 32'h15A);

        snap();
        do_read(8'hA5);
        chk("r_a5_led", {22'd0, led_out}, 32'h15A);
        chk("r_a5_oe", oe_cycles - o0, 32'd3);
        chk("r_a5_addr", {24'd0, addr_out}, 32'hA5);
        chk("r_a5_idle", {31'd0, ce_n}, 32'd1);

        do_write(8'h00, 10'h001);
        chk("w_00_addr", {24'd0, addr_out}, 32'h00);
        do_write(8'hFF, 10'h3FF);
        chk("w_ff_addr", {24'd0, addr_out}, 32'hFF);
        do_read(8'h00);
        chk("r_00_led", {22'd0, led_out}, 32'h001);
        chk("r_00_addr", {24'd0, addr_out}, 32'h00);
        do_read(8'hFF);
        chk("r_ff_led", {22'd0, led_out}, 32'h3FF);
        chk("r_ff_addr", {24'd0, addr_out}, 32'hFF);

        snap();
        addr_in = 8'h10; data_in = 10'h2AA;
        write_req = 1'b0; read_req = 1'b0;
        tick(1);
        write_req = 1'b1; read_req = 1'b1;
        tick(10);
        chk("simul_pulses", we_pulses - p0, 32'd1);
        chk("simul_no_oe", oe_cycles - o0, 32'd0);
        chk("simul_led", {22'd0, led_out}, 32'h3FF);
        chk("simul_mem", {22'd0, mem[8'h10]}, 32'h2AA);
        chk("simul_addr", {24'd0, addr_out}, 32'h10);

        snap();
        addr_in = 8'h20; data_in = 10'h0F0;
        write_req = 1'b0;
        tick(50);
        write_req = 1'b1;
        tick(10);
        chk("hold_pulses", we_pulses - p0, 32'd1);
        chk("hold_low", we_low - l0, 32'd2);
        chk("hold_mem", {22'd0, mem[8'h20]}, 32'h0F0);

        snap();
        addr_in = 8'h40; data_in = 10'h0AA;
        write_req = 1'b0;
        tick(1);
        write_req = 1'b1;
        tick(3);
        read_req = 1'b0;
        tick(1);
        read_req = 1'b1;
        tick(8);
        chk("busy_read_dropped", oe_cycles - o0, 32'd0);
        chk("busy_write_pulses", we_pulses - p0, 32'd1);
        chk("busy_led", {22'd0, led_out}, 32'h3FF);

        snap();
        addr_in = 8'h30; data_in = 10'h155;
        write_req = 1'b0;
        tick(1);
        write_req = 1'b1;
        tick(3);
        chk("abort_in_pulse", {31'd0, we_n}, 32'd0);
        rst = 1'b1;
        tick(1);
        chk("abort_we_n", {31'd0, we_n}, 32'd1);
        chk("abort_ce_n", {31'd0, ce_n}, 32'd1);
        chk("abort_oe_n", {31'd0, oe_n}, 32'd1);
        chk("abort_led", {22'd0, led_out}, 32'h0);
        chk("abort_addr", {24'd0, addr_out}, 32'h0);
        rst = 1'b0;
        tick(10);
        chk("abort_stays_idle", {31'd0, ce_n}, 32'd1);
        chk("abort_one_low", we_low - l0, 32'd1);
        chk("abort_no_oe", oe_cycles - o0, 32'd0);

        do_read(8'hA5);
        chk("post_rst_led", {22'd0, led_out}, 32'h15A);
        chk("post_rst_addr", {24'd0, addr_out}, 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/top_sram.md
TOP_SRAM -- requirements
Module: top_sram

Interface
REQ-001 Parameter ADDR_W, default 8: SRAM address width.
REQ-002 Parameter DATA_W, default 10: SRAM data width and LED width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 addr_in  input  ADDR_W  target address from switches.
REQ-007 data_in  input  DATA_W  write data from switches.
REQ-008 write_req  input  1  active-low write button, asynchronous to clk.
REQ-009 read_req  input  1  active-low read button, asynchronous to clk.
REQ-010 led_out  output  DATA_W  last data read from SRAM.
REQ-011 we_n  output  1  SRAM write enable, active low.
REQ-012 oe_n  output  1  SRAM output enable, active low.
REQ-013 ce_n  output  1  SRAM chip enable, active low.
REQ-014 addr_out  output  ADDR_W  SRAM address bus.
REQ-015 sram_dq  inout  DATA_W  SRAM data bus; driven only in write states, else high-Z.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer, then falling-edge detection; one press = one request, regardless of hold time.
REQ-017 FSM states SHALL be IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, R_LATCH, all registered outputs.
REQ-018 IDLE: ce_n=we_n=oe_n=1, sram_dq high-Z; on write edge latch addr_in/data_in and go W_SETUP; else on read edge latch addr_in and go R_SETUP.
REQ-019 Simultaneous write and read edges SHALL execute the write only; the read edge is dropped.
REQ-020 Edges arriving while not in IDLE SHALL be ignored (no queuing).
REQ-021 W_SETUP (1 cycle): ce_n=0, we_n=1, oe_n=1, addr_out and sram_dq driven with latched values.
REQ-022 W_PULSE (2 cycles): we_n=0, address and data held stable; the address and data SHALL be valid before we_n falls.
REQ-023 W_HOLD (1 cycle): we_n=1, address/data still driven, ce_n=0; then IDLE.
REQ-024 R_SETUP (1 cycle): ce_n=0, oe_n=0, we_n=1, sram_dq high-Z, addr_out=latched address.
REQ-025 R_WAIT (1 cycle): same outputs as R_SETUP.
REQ-026 R_LATCH (1 cycle): led_out SHALL load sram_dq at the end of this cycle; oe_n/ce_n remain 0; then IDLE.
REQ-027 sram_dq SHALL never be driven while oe_n=0.
REQ-028 addr_out SHALL hold its last value in IDLE; led_out SHALL hold until the next R_LATCH.
REQ-029 Latency: write completes (return to IDLE) at most 8 cycles, read at most 7 cycles, after the button falling edge.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, we_n=oe_n=ce_n=1, addr_out=0, led_out=0, sram_dq high-Z, synchronizers set to 1 (released).
REQ-031 Reset mid-operation SHALL abort the access immediately; no request is remembered afterwards.

Configuration
REQ-032 Macro BTN_DEBOUNCE_EN: when defined, each synchronized button SHALL be stable low for DEBOUNCE_CYCLES (parameter, default 4) consecutive cycles before a request is generated, and must return high before a new request; when undefined, the raw synchronized falling edge is the request (REQ-016).

Verification
REQ-033 Write addr_in=A5, data_in=15A, write_req low 1 cycle; then read A5 -> SRAM model holds 15A at A5, led_out=15A.
REQ-034 Write 00->001 and FF->3FF, read both -> led_out 001 then 3FF; addr_out matches each access.
REQ-035 write_req and read_req fall on the same cycle -> one write pulse, no oe_n assertion, led_out unchanged.
REQ-036 write_req held low 50 cycles -> exactly one we_n low pulse of 2 cycles.
REQ-037 rst asserted during W_PULSE -> next cycle we_n=ce_n=1, sram_dq high-Z, led_out=0, FSM idle.
REQ-038 During every read, sram_dq is never driven by the DUT (no bus contention; no X observed on sram_dq).
